// File: rtl/aclock_pkg.sv
// Shared types and BCD helpers for the multi-alarm clock.
// Snooze support is compiled in only when ACLOCK_SNOOZE_EN is defined (see aclock_multi).
package aclock_pkg;

    localparam int unsigned MAX_H1      = 2;
    localparam int unsigned MAX_H0_TOP  = 3;
    localparam int unsigned MAX_M1      = 5;
    localparam int unsigned MAX_S1      = 5;
    localparam int unsigned MAX_DIGIT   = 9;
    localparam int unsigned MIN_PER_DAY = 1440;
    localparam int unsigned HHMM_W      = 14;
    localparam int unsigned TIME_W      = 22;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } hhmm_t;

    // True when the value is a legal 00:00..23:59 BCD time.
    function automatic logic hhmm_valid(hhmm_t v);
        return !((v.h0 > 4'(MAX_DIGIT)) || (v.m1 > 4'(MAX_M1)) || (v.m0 > 4'(MAX_DIGIT)) ||
                 (v.h1 > 2'(MAX_H1)) ||
                 ((v.h1 == 2'(MAX_H1)) && (v.h0 > 4'(MAX_H0_TOP))));
    endfunction

    function automatic hhmm_t hhmm_of(bcd_time_t t);
        hhmm_t r;
        r.h1 = t.h1;
        r.h0 = t.h0;
        r.m1 = t.m1;
        r.m0 = t.m0;
        return r;
    endfunction

    // One-second BCD increment with minute/hour/day carries.
    function automatic bcd_time_t time_inc(bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s0 != 4'(MAX_DIGIT)) begin
            r.s0 = t.s0 + 4'd1;
        end else begin
            r.s0 = 4'd0;
            if (t.s1 != 4'(MAX_S1)) begin
                r.s1 = t.s1 + 4'd1;
            end else begin
                r.s1 = 4'd0;
                if (t.m0 != 4'(MAX_DIGIT)) begin
                    r.m0 = t.m0 + 4'd1;
                end else begin
                    r.m0 = 4'd0;
                    if (t.m1 != 4'(MAX_M1)) begin
                        r.m1 = t.m1 + 4'd1;
                    end else begin
                        r.m1 = 4'd0;
                        if ((t.h1 == 2'(MAX_H1)) && (t.h0 == 4'(MAX_H0_TOP))) begin
                            r.h1 = 2'd0;
                            r.h0 = 4'd0;
                        end else if (t.h0 == 4'(MAX_DIGIT)) begin
                            r.h0 = 4'd0;
                            r.h1 = t.h1 + 2'd1;
                        end else begin
                            r.h0 = t.h0 + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    // HH:MM plus a minute offset (< 60), wrapping at midnight.
    function automatic hhmm_t hhmm_add_min(hhmm_t v, int unsigned add);
        logic [10:0] tot;
        logic [4:0]  h;
        logic [5:0]  m;
        hhmm_t       r;
        tot = 11'(v.h1) * 11'd600 + 11'(v.h0) * 11'd60 + 11'(v.m1) * 11'd10 + 11'(v.m0) + 11'(add);
        if (tot >= 11'(MIN_PER_DAY)) tot = tot - 11'(MIN_PER_DAY);
        h    = 5'(tot / 11'd60);
        m    = 6'(tot % 11'd60);
        r.h1 = 2'(h / 5'd10);
        r.h0 = 4'(h % 5'd10);
        r.m1 = 4'(m / 6'd10);
        r.m0 = 4'(m % 6'd10);
        return r;
    endfunction

endpackage

// File: rtl/aclock_alarm_ch.sv
// One alarm channel: HH:MM register, match rising-edge detect and ringing latch.
module aclock_alarm_ch
    import aclock_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_i,
    input  logic [HHMM_W-1:0] ld_val_i,
    input  logic [HHMM_W-1:0] cur_i,
    input  logic              al_on_i,
    input  logic              stop_i,
    input  logic              hush_i,
    input  logic              rering_i,
    output logic              ring_o,
    output logic              ring_nxt_c
);

    hhmm_t alarm_q, alarm_d;
    logic  match_q, match_c;
    logic  ring_q, ring_d;

    // Stop/disable beat snooze-hush, which beats a fresh match or re-ring.
    always_comb begin
        alarm_d = alarm_q;
        ring_d  = ring_q;
        if (ld_i) alarm_d = hhmm_t'(ld_val_i);
        match_c = al_on_i && (hhmm_t'(cur_i) == alarm_q);
        if (stop_i || !al_on_i) begin
            ring_d = 1'b0;
        end else if (hush_i) begin
            ring_d = 1'b0;
        end else if ((match_c && !match_q) || rering_i) begin
            ring_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_q <= '0;
            match_q <= 1'b0;
            ring_q  <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
            match_q <= match_c;
            ring_q  <= ring_d;
        end
    end

    assign ring_o     = ring_q;
    assign ring_nxt_c = ring_d;

endmodule

// File: rtl/aclock_multi.sv
// BCD time-of-day clock with NUM_ALARMS independent alarm channels.
// Defining ACLOCK_SNOOZE_EN adds the SNOOZE port and shared snooze-target logic.
module aclock_multi
    import aclock_pkg::*;
#(
    parameter  int unsigned NUM_ALARMS    = 4,
    parameter  int unsigned TICKS_PER_SEC = 10,
    parameter  int unsigned SNOOZE_MIN    = 5,
    localparam int unsigned SEL_W         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [3:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic                  LD_time,
    input  logic                  LD_alarm,
    input  logic [SEL_W-1:0]      al_sel,
    input  logic [NUM_ALARMS-1:0] AL_ON,
    input  logic                  STOP_al,
`ifdef ACLOCK_SNOOZE_EN
    input  logic                  SNOOZE,
`endif
    output logic                  Alarm,
    output logic [NUM_ALARMS-1:0] Alarm_vec,
    output logic [1:0]            H_out1,
    output logic [3:0]            H_out0,
    output logic [3:0]            M_out1,
    output logic [3:0]            M_out0,
    output logic [3:0]            S_out1,
    output logic [3:0]            S_out0
);

    localparam int unsigned PRE_W = $clog2(TICKS_PER_SEC);

    if ((NUM_ALARMS < 1) || (NUM_ALARMS > 8) || (TICKS_PER_SEC < 2) ||
        (SNOOZE_MIN < 1) || (SNOOZE_MIN > 59)) begin : g_param_err
        $error("aclock_multi: parameter out of range");
    end

    bcd_time_t             time_q, time_d;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic                  alarm_q;
    logic                  tick_c, ld_ok_c, ld_time_c, ld_alarm_c;
    hhmm_t                 ld_val_c, cur_hhmm_c;
    logic                  hush_c;
    logic [NUM_ALARMS-1:0] rering_c, ring_vec, ring_nxt;

    // Prescaler and timekeeping; a valid time load overrides a coincident tick.
    always_comb begin
        ld_val_c   = {H_in1, H_in0, M_in1, M_in0};
        ld_ok_c    = hhmm_valid(ld_val_c);
        ld_time_c  = LD_time && ld_ok_c;
        ld_alarm_c = LD_alarm && ld_ok_c && (32'(al_sel) < NUM_ALARMS);
        cur_hhmm_c = hhmm_of(time_q);
        tick_c     = (presc_q == PRE_W'(TICKS_PER_SEC - 1));
        time_d     = time_q;
        presc_d    = presc_q + PRE_W'(1);
        if (tick_c) begin
            presc_d = '0;
            time_d  = time_inc(time_q);
        end
        if (ld_time_c) begin
            presc_d = '0;
            time_d  = {ld_val_c, 4'd0, 4'd0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            time_q  <= '0;
            presc_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            time_q  <= time_d;
            presc_q <= presc_d;
            alarm_q <= |ring_nxt;
        end
    end

`ifdef ACLOCK_SNOOZE_EN
    logic [NUM_ALARMS-1:0] pend_q, pend_d;
    hhmm_t                 target_q, target_d;
    logic                  snooze_act_c, at_target_c;

    // Snooze parks the ringing channels until the shared target minute arrives.
    always_comb begin
        snooze_act_c = SNOOZE && alarm_q;
        at_target_c  = (|pend_q) && (cur_hhmm_c == target_q);
        pend_d       = pend_q;
        target_d     = target_q;
        if (STOP_al) begin
            pend_d = '0;
        end else if (snooze_act_c) begin
            pend_d   = pend_q | ring_vec;
            target_d = hhmm_add_min(cur_hhmm_c, SNOOZE_MIN);
        end else if (at_target_c) begin
            pend_d = '0;
        end
        hush_c   = snooze_act_c;
        rering_c = at_target_c ? pend_q : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q   <= '0;
            target_q <= '0;
        end else begin
            pend_q   <= pend_d;
            target_q <= target_d;
        end
    end
`else
    assign hush_c   = 1'b0;
    assign rering_c = '0;
`endif

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        aclock_alarm_ch u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .ld_i       (ld_alarm_c && (al_sel == SEL_W'(i))),
            .ld_val_i   (ld_val_c),
            .cur_i      (cur_hhmm_c),
            .al_on_i    (AL_ON[i]),
            .stop_i     (STOP_al),
            .hush_i     (hush_c),
            .rering_i   (rering_c[i]),
            .ring_o     (ring_vec[i]),
            .ring_nxt_c (ring_nxt[i])
        );
    end

    assign Alarm     = alarm_q;
    assign Alarm_vec = ring_vec;
    assign H_out1    = time_q.h1;
    assign H_out0    = time_q.h0;
    assign M_out1    = time_q.m1;
    assign M_out0    = time_q.m0;
    assign S_out1    = time_q.s1;
    assign S_out0    = time_q.s0;

endmodule
